fetch_pc_unit: RTL and testbench
================================

Name: fetch_pc_unit

Overview:
- Fetch stage that owns the 16-bit program counter and issues instruction fetches.
- Consumes the next-PC value selected by the 16-bit 2:1 mux (branch target vs. sequential); that mux's O drives BT here.
- Holds the fetched instruction in IR until decode accepts it with ADV.

Parameters:
WIDTH, 16, datapath/address width
RESET_VEC, 16'h0000, PC value loaded on reset
INC, 2, sequential PC increment (byte-addressed 16-bit words)
TIMEOUT_CYC, 15, FETCH cycles without FACK before error (FETCH_TIMEOUT_EN only)

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  reset, synchronous, active-low
BT  input  WIDTH  branch/flush target from next-PC mux output
BR  input  1  take BT instead of PC+INC on advance
ADV  input  1  decode accepts IR this cycle
FLUSH  input  1  discard current fetch/IR, redirect to BT
IDATA  input  WIDTH  instruction memory read data
FACK  input  1  instruction memory ack, IDATA valid this cycle
ADDR  output  WIDTH  fetch address (= PC)
FREQ  output  1  fetch request
PC  output  WIDTH  current program counter
IR  output  WIDTH  instruction register
IRV  output  1  IR holds valid instruction
ERR  output  1  fetch timeout error, sticky

Behaviour:
- Interface: one clock CLK; reset RST_N is synchronous, active-low; all state updates on CLK rising edge.
- Reset (RST_N=0 at edge, any state, including mid-fetch): PC=RESET_VEC, IR=0, IRV=0, FREQ=0, ERR=0, timeout count=0, state BOOT. Pending FACK ignored.
- ADDR = PC combinationally; FREQ registered, high exactly in FETCH.
- States: BOOT, FETCH, HOLD, HALT.
- BOOT: one cycle, then FETCH.
- FETCH: FREQ=1. On FACK=1: IR<=IDATA, IRV<=1, go HOLD (IRV visible the cycle after ack, latency 1).
- HOLD: IRV=1, FREQ=0, IR stable. On ADV=1: PC<=BR ? BT : PC+INC, IRV<=0, go FETCH. ADV=0: stay; BR ignored when ADV=0.
- FLUSH=1 (BOOT, FETCH, HOLD): PC<=BT, IRV<=0, go FETCH. Takes priority over FACK and ADV in the same cycle; IDATA discarded.
- ADV or FACK in states where not expected: ignored.
- Arithmetic: PC+INC modulo 2^WIDTH (0xFFFE+2 -> 0x0000); BT loaded unmodified.
- Minimum loop: FETCH(ack) -> HOLD(adv) -> FETCH = 2 cycles per instruction.
- HALT: reachable only with the optional feature; exit only by reset.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined: counter increments each FETCH cycle with FACK=0, clears on leaving FETCH or on FLUSH.
  - When count reaches TIMEOUT_CYC: ERR<=1 (sticky), FREQ<=0, go HALT.
  - FLUSH is ignored in HALT.
- Undefined: no counter, ERR tied 0, FETCH waits indefinitely for FACK.

Test Plan:
- Reset then FACK with IDATA=16'h1234 on the 2nd FETCH cycle -> ADDR=0x0000, FREQ=1 from cycle 2; IR=0x1234, IRV=1 the next cycle.
- HOLD, ADV=1, BR=0 -> PC 0x0000->0x0002, IRV=0, FREQ=1; with BR=1, BT=0x00A0 -> PC=0x00A0.
- PC=0xFFFE, ADV=1, BR=0 -> PC=0x0000 (wrap).
- FETCH with FACK=1, FLUSH=1, BT=0x0040, IDATA=0xBEEF in the same cycle -> IRV stays 0, IR unchanged, PC=0x0040, still FETCH.
- RST_N=0 for one edge while in HOLD with IRV=1 -> PC=RESET_VEC, IRV=0, FREQ=0, then BOOT->FETCH.
- FETCH_TIMEOUT_EN defined, no FACK for 15 cycles -> ERR=1, FREQ=0, HALT ignores FLUSH; undefined -> ERR stays 0, FREQ stays 1.

Source files
------------

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory fetch bus between the fetch stage (master) and memory (slave).
interface fetch_pc_unit_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] addr;
  logic             freq;
  logic [WIDTH-1:0] idata;
  logic             fack;

  modport master (
    output addr,
    output freq,
    input  idata,
    input  fack
  );

  modport slave (
    input  addr,
    input  freq,
    output idata,
    output fack
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch stage: owns the program counter, issues fetches, holds IR until decode advances.
// Optional fetch timeout with sticky error and HALT state: define FETCH_TIMEOUT_EN.
module fetch_pc_unit #(
  parameter int                     WIDTH       = 16,
  parameter logic [WIDTH-1:0]       RESET_VEC   = '0,
  parameter int                     INC         = 2,
  parameter int                     TIMEOUT_CYC = 15
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [WIDTH-1:0]  bt_i,
  input  logic              br_i,
  input  logic              adv_i,
  input  logic              flush_i,
  fetch_pc_unit_if.master   imem,
  output logic [WIDTH-1:0]  pc_o,
  output logic [WIDTH-1:0]  ir_o,
  output logic              irv_o,
  output logic              err_o
);

  localparam logic [1:0] BOOT  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  localparam logic [1:0] HALT  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic             irv_q, irv_d;
  logic             freq_q, freq_d;
  logic [WIDTH-1:0] pc_seq;

  assign pc_seq = pc_q + WIDTH'(INC);

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    irv_d   = irv_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      BOOT: begin
        if (flush_i) pc_d = bt_i;
        state_d = FETCH;
      end
      FETCH: begin
        // FLUSH wins over an ack in the same cycle; the returned word is dropped
        if (flush_i) begin
          pc_d  = bt_i;
          irv_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
          cnt_d = '0;
`endif
        end else if (imem.fack) begin
          ir_d    = imem.idata;
          irv_d   = 1'b1;
          state_d = HOLD;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = HALT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      HOLD: begin
        if (flush_i) begin
          pc_d    = bt_i;
          irv_d   = 1'b0;
          state_d = FETCH;
        end else if (adv_i) begin
          pc_d    = br_i ? bt_i : pc_seq;
          irv_d   = 1'b0;
          state_d = FETCH;
        end
      end
      default: state_d = HALT;
    endcase
    freq_d = (state_d == FETCH);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= BOOT;
      pc_q    <= RESET_VEC;
      ir_q    <= '0;
      irv_q   <= 1'b0;
      freq_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      irv_q   <= irv_d;
      freq_q  <= freq_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  assign imem.addr = pc_q;
  assign imem.freq = freq_q;
  assign pc_o      = pc_q;
  assign ir_o      = ir_q;
  assign irv_o     = irv_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomized bench for fetch_pc_unit against a flag-based behavioural model.
// Follows FETCH_TIMEOUT_EN the same way the design does.
module tb_fetch_pc_unit;

  logic        clk;
  logic        rstN;
  logic [15:0] bt;
  logic        br;
  logic        adv;
  logic        flush;
  logic [15:0] pc;
  logic [15:0] ir;
  logic        irv;
  logic        err;

  fetch_pc_unit_if #(.WIDTH(16)) imemIf ();

  fetch_pc_unit dut (
    .clk_i   (clk),
    .rst_ni  (rstN),
    .bt_i    (bt),
    .br_i    (br),
    .adv_i   (adv),
    .flush_i (flush),
    .imem    (imemIf),
    .pc_o    (pc),
    .ir_o    (ir),
    .irv_o   (irv),
    .err_o   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: booting / halted / holding flags plus a count of unanswered fetch cycles
  logic [15:0] mPc;
  logic [15:0] mIr;
  logic        mHolding;
  logic        mBooting;
  logic        mHalted;
  logic        mErr;
  int          mWait;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelStep(input logic r, input logic f, input logic k, input logic a,
                           input logic b, input logic [15:0] t, input logic [15:0] d);
    if (!r) begin
      mPc = 16'h0000; mIr = 16'h0000; mHolding = 0; mErr = 0;
      mBooting = 1; mHalted = 0; mWait = 0;
    end else if (mHalted) begin
    end else if (mBooting) begin
      mBooting = 0;
      if (f) mPc = t;
    end else if (f) begin
      mPc = t; mHolding = 0; mWait = 0;
    end else if (mHolding) begin
      if (a) begin
        mPc = b ? t : mPc + 16'd2;
        mHolding = 0;
      end
    end else if (k) begin
      mIr = d; mHolding = 1; mWait = 0;
    end else begin
`ifdef FETCH_TIMEOUT_EN
      mWait++;
      if (mWait == 15) begin
        mErr = 1; mHalted = 1;
      end
`endif
    end
  endtask

  task automatic checkAll(input string tag);
    logic expFreq;
    expFreq = !mBooting && !mHalted && !mHolding;
    checkOutput({tag, ".pc"},   32'(pc),             32'(mPc));
    checkOutput({tag, ".addr"}, 32'(imemIf.addr),    32'(mPc));
    checkOutput({tag, ".freq"}, 32'(imemIf.freq),    32'(expFreq));
    checkOutput({tag, ".ir"},   32'(ir),             32'(mIr));
    checkOutput({tag, ".irv"},  32'(irv),            32'(mHolding));
    checkOutput({tag, ".err"},  32'(err),            32'(mErr));
  endtask

  task automatic applyStimulus(input string tag, input logic r, input logic f, input logic k,
                               input logic a, input logic b, input logic [15:0] t, input logic [15:0] d);
    @(negedge clk);
    rstN = r; flush = f; imemIf.fack = k; adv = a; br = b; bt = t; imemIf.idata = d;
    modelStep(r, f, k, a, b, t, d);
    @(posedge clk);
    #1;
    checkAll(tag);
  endtask

  initial begin
    rstN = 0; flush = 0; adv = 0; br = 0; bt = 0;
    imemIf.fack = 0; imemIf.idata = 0;

    // r, flush, fack, adv, br, bt, idata
    applyStimulus("reset", 0, 0, 1, 1, 0, 16'h0000, 16'h5555);
    applyStimulus("boot",  1, 0, 0, 0, 0, 16'h0000, 16'h0000);
    applyStimulus("fetch1", 1, 0, 0, 0, 0, 16'h0000, 16'h0000);
    applyStimulus("ack",   1, 0, 1, 0, 0, 16'h0000, 16'h1234);
    applyStimulus("holdNoAdv", 1, 0, 0, 0, 1, 16'h0FF0, 16'h0000);
    applyStimulus("advSeq", 1, 0, 0, 1, 0, 16'h0000, 16'h0000);
    applyStimulus("ack2",  1, 0, 1, 0, 0, 16'h0000, 16'hA5A5);
    applyStimulus("advBr", 1, 0, 0, 1, 1, 16'h00A0, 16'h0000);
    applyStimulus("flushFetch", 1, 1, 0, 0, 0, 16'hFFFE, 16'h0000);
    applyStimulus("ack3",  1, 0, 1, 0, 0, 16'h0000, 16'h7777);
    applyStimulus("wrap",  1, 0, 0, 1, 0, 16'h1111, 16'h0000);
    applyStimulus("flushAck", 1, 1, 1, 0, 0, 16'h0040, 16'hBEEF);
    applyStimulus("ack4",  1, 0, 1, 0, 0, 16'h0000, 16'hC0DE);
    applyStimulus("rstHold", 0, 0, 0, 1, 0, 16'h0000, 16'h0000);
    applyStimulus("boot2", 1, 0, 0, 0, 0, 16'h0000, 16'h0000);

    // Long stretch without ack: timeout build halts, default build keeps requesting
    for (int i = 0; i < 18; i++)
      applyStimulus("noAck", 1, 0, 0, 0, 0, 16'h0000, 16'h0000);
    applyStimulus("flushAfterWait", 1, 1, 1, 0, 0, 16'h0300, 16'h9999);
    applyStimulus("rstAfterWait", 0, 0, 0, 0, 0, 16'h0000, 16'h0000);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus("rand",
                    ($urandom_range(99) >= 2),
                    ($urandom_range(99) < 8),
                    ($urandom_range(99) < 45),
                    ($urandom_range(99) < 50),
                    ($urandom_range(1) == 1),
                    16'($urandom),
                    16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
